// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite memory responder: response codes, FSM states, arbitration grant.
// Pure type definitions; no latency or backpressure of its own.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [2:0] {
        IDLE,
        WR_MEM,
        WR_RESP,
        RD_MEM,
        RD_RESP
    } slave_state_t;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } grant_t;

endpackage

// File: rtl/axi4_lite_hold_reg.sv
// Single-entry valid/ready holding register; a beat is captured on the edge it handshakes, visible next cycle.
// Backpressure: rdy drops while full (and during reset) until clr empties the entry.
module axi4_lite_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld,
    output logic             rdy,
    input  logic [WIDTH-1:0] dat,
    input  logic             clr,
    output logic             full,
    output logic [WIDTH-1:0] hold_dat
);

    assign rdy = ~full & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full     <= 1'b0;
            hold_dat <= '0;
        end else if (clr) begin
            // Payload is kept; the consumer copies it out on the same edge.
            full <= 1'b0;
        end else if (vld && rdy) begin
            full     <= 1'b1;
            hold_dat <= dat;
        end
    end

endmodule

// File: rtl/axi4_lite_mem_slave.sv
// AXI4-Lite responder onto a single req/ack memory port, fair read/write arbitration, SLVERR on fault/timeout.
// Latency: AW/W or AR beat to B/R valid is 3 cycles with an immediate ack; one beat per channel buffered, ready low while held.
module axi4_lite_mem_slave
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    i_clk,
    input  logic                    i_arst,
    input  logic [ADDR_WIDTH-1:0]   i_awaddr,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    output logic [1:0]              o_bresp,
    output logic                    o_bvalid,
    input  logic                    i_bready,
    input  logic [ADDR_WIDTH-1:0]   i_araddr,
    input  logic                    i_arvalid,
    output logic                    o_arready,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic [1:0]              o_rresp,
    output logic                    o_rvalid,
    input  logic                    i_rready,
    output logic                    o_mem_req,
    output logic                    o_mem_we,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0] o_mem_wstrb,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
    input  logic                    i_mem_ack,
    input  logic                    i_mem_err
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_WIDTH  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    slave_state_t state, state_nxt;
    grant_t       last_grant;

    logic                  aw_full, w_full, ar_full;
    logic [ADDR_WIDTH-1:0] aw_addr_dat, ar_addr_dat;
    logic [DATA_WIDTH-1:0] w_data_dat;
    logic [STRB_WIDTH-1:0] w_strb_dat;

    logic grant_wr, grant_rd, tie;
    logic in_mem, timeout_hit;

    logic [CNT_WIDTH-1:0]  tmo_cnt;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic [STRB_WIDTH-1:0] acc_wstrb;

    logic                  bvalid_q, rvalid_q;
    resp_t                 bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    axi4_lite_hold_reg #(.WIDTH(ADDR_WIDTH)) u_aw_hold (
        .clk      (i_clk),
        .rst      (i_arst),
        .vld      (i_awvalid),
        .rdy      (o_awready),
        .dat      (i_awaddr),
        .clr      (grant_wr),
        .full     (aw_full),
        .hold_dat (aw_addr_dat)
    );

    axi4_lite_hold_reg #(.WIDTH(DATA_WIDTH + STRB_WIDTH)) u_w_hold (
        .clk      (i_clk),
        .rst      (i_arst),
        .vld      (i_wvalid),
        .rdy      (o_wready),
        .dat      ({i_wstrb, i_wdata}),
        .clr      (grant_wr),
        .full     (w_full),
        .hold_dat ({w_strb_dat, w_data_dat})
    );

    axi4_lite_hold_reg #(.WIDTH(ADDR_WIDTH)) u_ar_hold (
        .clk      (i_clk),
        .rst      (i_arst),
        .vld      (i_arvalid),
        .rdy      (o_arready),
        .dat      (i_araddr),
        .clr      (grant_rd),
        .full     (ar_full),
        .hold_dat (ar_addr_dat)
    );

    assign in_mem      = (state == WR_MEM) || (state == RD_MEM);
    assign timeout_hit = (tmo_cnt == TIMEOUT_LAST);

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_wr  = 1'b0;
        grant_rd  = 1'b0;
        tie       = 1'b0;
        unique case (state)
            IDLE: begin
                if (aw_full && w_full && ar_full) begin
                    tie      = 1'b1;
                    grant_wr = (last_grant == READ);
                    grant_rd = (last_grant == WRITE);
                end else if (aw_full && w_full) begin
                    grant_wr = 1'b1;
                end else if (ar_full) begin
                    grant_rd = 1'b1;
                end
                if (grant_wr) begin
                    state_nxt = WR_MEM;
                end else if (grant_rd) begin
                    state_nxt = RD_MEM;
                end
            end
            WR_MEM: begin
                if (i_mem_ack || timeout_hit) begin
                    state_nxt = WR_RESP;
                end
            end
            RD_MEM: begin
                if (i_mem_ack || timeout_hit) begin
                    state_nxt = RD_RESP;
                end
            end
            WR_RESP: begin
                if (i_bready) begin
                    state_nxt = IDLE;
                end
            end
            RD_RESP: begin
                if (i_rready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Copy the granted beat out so the holding registers can take the next one mid-access.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            last_grant <= READ;
            acc_addr   <= '0;
            acc_wdata  <= '0;
            acc_wstrb  <= '0;
        end else begin
            if (tie) begin
                last_grant <= grant_wr ? WRITE : READ;
            end
            if (grant_wr) begin
                acc_addr  <= aw_addr_dat;
                acc_wdata <= w_data_dat;
                acc_wstrb <= w_strb_dat;
            end else if (grant_rd) begin
                acc_addr  <= ar_addr_dat;
                acc_wdata <= '0;
                acc_wstrb <= '0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            tmo_cnt <= '0;
        end else if (in_mem && !i_mem_ack && !timeout_hit) begin
            tmo_cnt <= tmo_cnt + CNT_WIDTH'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

    // An ack arriving in the final timeout cycle still wins; after that, acks are ignored.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            bresp_q  <= OKAY;
            rresp_q  <= OKAY;
            rdata_q  <= '0;
        end else begin
            unique case (state)
                WR_MEM: begin
                    if (i_mem_ack) begin
                        bvalid_q <= 1'b1;
                        bresp_q  <= i_mem_err ? SLVERR : OKAY;
                    end else if (timeout_hit) begin
                        bvalid_q <= 1'b1;
                        bresp_q  <= SLVERR;
                    end
                end
                RD_MEM: begin
                    if (i_mem_ack) begin
                        rvalid_q <= 1'b1;
                        rresp_q  <= i_mem_err ? SLVERR : OKAY;
                        rdata_q  <= i_mem_rdata;
                    end else if (timeout_hit) begin
                        rvalid_q <= 1'b1;
                        rresp_q  <= SLVERR;
                        rdata_q  <= '0;
                    end
                end
                WR_RESP: begin
                    if (i_bready) begin
                        bvalid_q <= 1'b0;
                    end
                end
                RD_RESP: begin
                    if (i_rready) begin
                        rvalid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_bvalid    = bvalid_q;
    assign o_bresp     = bresp_q;
    assign o_rvalid    = rvalid_q;
    assign o_rresp     = rresp_q;
    assign o_rdata     = rdata_q;

    assign o_mem_req   = in_mem;
    assign o_mem_we    = (state == WR_MEM);
    assign o_mem_addr  = in_mem ? acc_addr  : '0;
    assign o_mem_wdata = in_mem ? acc_wdata : '0;
    assign o_mem_wstrb = in_mem ? acc_wstrb : '0;

endmodule
